operand_deserializer: RTL and testbench
=======================================

// Module: operand_deserializer
// PURPOSE
//   Serial-to-parallel operand loader directly upstream of the 3-bit median filter stage.
//   Assembles a WIDTH-bit operand from a framed 1-bit serial stream.
//   Holds the operand stable on operandX with a valid/ready handshake until the filter side accepts it.
//   Flags framing errors and overruns.
// PARAMETERS
//   WIDTH      6   operand width in bits; must be >= 3 (median filter window)
//   LSB_FIRST  1   1: first serial bit -> operandX[0]; 0: first bit -> operandX[WIDTH-1]
// PORTS
//   clk           in   1      single clock, rising edge
//   reset         in   1      synchronous, active-high reset
//   serIn         in   1      serial data bit
//   serValid      in   1      serIn carries a valid bit this cycle
//   serStart      in   1      qualifies serValid: this bit is bit 0 of a new frame
//   operandX      out  WIDTH  assembled operand; feeds the median filter operandX input
//   operandValid  out  1      operandX holds a complete frame
//   operandReady  in   1      downstream accepts operandX this cycle
//   frameError    out  1      1-cycle pulse: serStart seen mid-frame
//   overrun       out  1      1-cycle pulse: serial beat dropped while holding
//   busy          out  1      high in SHIFT or HOLD
// BEHAVIOUR
//   Reset: all outputs 0, state IDLE, bit counter 0, shift register 0.
//   Reset wins over every other input; a partial frame or held operand is discarded.
//   Beat = serValid high. Accept = operandValid && operandReady.
//   FSM states: IDLE, SHIFT, HOLD (encoding from the shared package).
//   IDLE:
//     - beat with serStart: store bit 0, count=1, go to SHIFT.
//     - beat without serStart: ignored; no error.
//   SHIFT:
//     - beat without serStart: store bit at position count, count++.
//     - when the stored bit is bit WIDTH-1: go to HOLD.
//     - beat with serStart: frameError pulses next cycle; frame restarts with this bit as bit 0, count=1.
//     - no beat: state holds; there is no timeout.
//   HOLD:
//     - operandValid=1; operandX is stable and unchanged until accept.
//     - accept with no beat: go to IDLE, operandValid=0 next cycle.
//     - accept with beat+serStart: start a new frame (count=1, SHIFT); back-to-back frames lose no cycle.
//     - beat without accept: beat dropped, overrun pulses next cycle, state stays HOLD.
//     - accept with beat and no serStart: beat dropped, overrun pulses, go to IDLE.
//   Latency: operandValid rises the cycle after the WIDTH-th beat (registered output).
//   Bit placement:
//     - LSB_FIRST=1: bit k -> operandX[k].
//     - LSB_FIRST=0: bit k -> operandX[WIDTH-1-k].
//   operandX:
//     - registered; updates only when entering HOLD.
//     - keeps its last value in IDLE/SHIFT; operandValid qualifies it.
//   Counter width is $clog2(WIDTH+1); it never exceeds WIDTH.
//   frameError and overrun are never asserted together with reset or in the cycle after reset.
// STRUCTURE
//   Shared package alu_pkg:
//     - OPERAND_WIDTH = 6
//     - typedef deser_state_t {IDLE, SHIFT, HOLD}
//   Sub-module: none required. FSM, counter and shift register fit in one file (~150 lines).
//   Top-level instantiates this block and feeds operandX straight into the median filter.
// TESTING
//   1. Reset, then serialise 6'b101101, LSB first (beats 1,0,1,1,0,1; serStart on first),
//      operandReady=0 -> operandX=6'h2D, operandValid=1 on cycle 7;
//      held for 10 idle cycles; operandReady=1 -> operandValid=0 next cycle.
//   2. Back-to-back: frame 6'h3F then 6'h00. serStart of frame 2 coincides with accept of frame 1
//      -> no idle cycle; second operandX=6'h00.
//   3. Mid-frame restart: 3 bits sent, then serStart with bits of 6'h15
//      -> frameError pulses exactly 1 cycle; final operandX=6'h15.
//   4. Overrun: hold 6'h2A with operandReady=0; send 2 beats -> overrun pulses twice; operandX stays 6'h2A.
//   5. Reset mid-frame after 4 bits -> all outputs 0 next cycle; a following full frame 6'h0C loads correctly.
//   6. LSB_FIRST=0: beats 1,0,1,1,0,1 -> operandX=6'h2D reversed = 6'b101101 MSB-first, i.e. 6'h2D;
//      repeat with 1,1,0,0,0,0 -> operandX=6'h30.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the operand path that feeds the median filter.
package alu_pkg;
  localparam int OPERAND_WIDTH = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } deser_state_t;
endpackage

// File: rtl/operand_deserializer.sv
// Framed serial-to-parallel loader: assembles WIDTH-bit operands and holds each one
// under a valid/ready handshake, flagging mid-frame restarts and dropped beats.
module operand_deserializer
  import alu_pkg::*;
#(
  parameter int WIDTH     = OPERAND_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             serIn,
  input  logic             serValid,
  input  logic             serStart,
  output logic [WIDTH-1:0] operandX,
  output logic             operandValid,
  input  logic             operandReady,
  output logic             frameError,
  output logic             overrun,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ZERO = '0;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  deser_state_t     state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [WIDTH-1:0] opx_q, opx_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic beat, accept, last_bit;
  logic [WIDTH-1:0] merged;

  // One-hot image of serial bit number c at its operand position.
  function automatic logic [WIDTH-1:0] place(input logic [CW-1:0] c, input logic b);
    logic [WIDTH-1:0] v;
    int p;
    p = LSB_FIRST ? int'(c) : (WIDTH - 1 - int'(c));
    v = '0;
    for (int k = 0; k < WIDTH; k++) v[k] = (k == p) ? b : 1'b0;
    return v;
  endfunction

  assign beat     = serValid;
  assign accept   = (state_q == HOLD) && operandReady;
  assign last_bit = (cnt_q == CNT_LAST);
  assign merged   = sreg_q | place(cnt_q, serIn);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sreg_q  <= '0;
      opx_q   <= '0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      opx_q   <= opx_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat && serStart) state_d = SHIFT;
      SHIFT:   if (beat && !serStart && last_bit) state_d = HOLD;
      HOLD: begin
        if (accept) state_d = (beat && serStart) ? SHIFT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter, shift register, held operand and error pulses.
  always_comb begin
    cnt_d  = cnt_q;
    sreg_d = sreg_q;
    opx_d  = opx_q;
    ferr_d = 1'b0;
    ovr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat && serStart) begin
          sreg_d = place(CNT_ZERO, serIn);
          cnt_d  = CNT_ONE;
        end
      end
      SHIFT: begin
        if (beat && serStart) begin
          ferr_d = 1'b1;
          sreg_d = place(CNT_ZERO, serIn);
          cnt_d  = CNT_ONE;
        end else if (beat && last_bit) begin
          opx_d  = merged;
          sreg_d = '0;
          cnt_d  = CNT_ZERO;
        end else if (beat) begin
          sreg_d = merged;
          cnt_d  = cnt_q + CNT_ONE;
        end
      end
      HOLD: begin
        if (accept && beat && serStart) begin
          sreg_d = place(CNT_ZERO, serIn);
          cnt_d  = CNT_ONE;
        end else if (beat) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        cnt_d  = CNT_ZERO;
        sreg_d = '0;
      end
    endcase
  end

  always_comb begin
    operandX     = opx_q;
    operandValid = (state_q == HOLD);
    busy         = (state_q != IDLE);
    frameError   = ferr_q;
    overrun      = ovr_q;
  end
endmodule

// File: tb/tb_operand_deserializer.sv
// Directed bench for operand_deserializer: a frame-level model checked every cycle,
// plus literal expectations at key points for both bit orders.
module tb_operand_deserializer;
  localparam int W = 6;

  logic clk = 1'b0;
  logic reset, serIn, serValid, serStart, operandReady;
  logic [W-1:0] opx_l, opx_m;
  logic vld_l, vld_m, ferr_l, ferr_m, ovr_l, ovr_m, busy_l, busy_m;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  operand_deserializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .reset(reset), .serIn(serIn), .serValid(serValid), .serStart(serStart),
    .operandX(opx_l), .operandValid(vld_l), .operandReady(operandReady),
    .frameError(ferr_l), .overrun(ovr_l), .busy(busy_l));

  operand_deserializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .reset(reset), .serIn(serIn), .serValid(serValid), .serStart(serStart),
    .operandX(opx_m), .operandValid(vld_m), .operandReady(operandReady),
    .frameError(ferr_m), .overrun(ovr_m), .busy(busy_m));

  // Frame-level model: collected bits of the current frame, and the held operand.
  bit     m_bits[$];
  bit     m_inframe, m_holding, m_ferr, m_ovr;
  int     m_opx_l, m_opx_m;

  task automatic load_from_bits();
    m_opx_l = 0;
    m_opx_m = 0;
    foreach (m_bits[k]) begin
      m_opx_l += int'(m_bits[k]) << k;
      m_opx_m += int'(m_bits[k]) << (W - 1 - k);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_bits.delete();
      m_inframe = 0; m_holding = 0; m_ferr = 0; m_ovr = 0;
      m_opx_l = 0; m_opx_m = 0;
    end else begin
      m_ferr = 0;
      m_ovr  = 0;
      if (m_holding) begin
        if (operandReady) begin
          m_holding = 0;
          if (serValid && serStart) begin
            m_bits.delete(); m_bits.push_back(serIn); m_inframe = 1;
          end else if (serValid) m_ovr = 1;
        end else if (serValid) m_ovr = 1;
      end else if (m_inframe) begin
        if (serValid) begin
          if (serStart) begin
            m_ferr = 1; m_bits.delete();
          end
          m_bits.push_back(serIn);
          if (m_bits.size() == W) begin
            load_from_bits();
            m_holding = 1; m_inframe = 0; m_bits.delete();
          end
        end
      end else if (serValid && serStart) begin
        m_bits.delete(); m_bits.push_back(serIn); m_inframe = 1;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_opx_l",  int'(opx_l),  m_opx_l);
      chk("cyc_opx_m",  int'(opx_m),  m_opx_m);
      chk("cyc_valid",  int'({vld_l, vld_m}),   {30'd0, m_holding, m_holding});
      chk("cyc_ferr",   int'({ferr_l, ferr_m}), {30'd0, m_ferr, m_ferr});
      chk("cyc_ovr",    int'({ovr_l, ovr_m}),   {30'd0, m_ovr, m_ovr});
      chk("cyc_busy",   int'({busy_l, busy_m}),
          {30'd0, m_holding | m_inframe, m_holding | m_inframe});
    end
  end

  task automatic drive(input bit v, input bit s, input bit b, input bit r);
    serValid = v; serStart = s; serIn = b; operandReady = r;
    @(posedge clk); #1;
  endtask

  task automatic send_frame(input bit [W-1:0] bits, input bit r);
    for (int k = 0; k < W; k++) drive(1'b1, k == 0, bits[k], r);
  endtask

  task automatic idle(input int n, input bit r);
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, r);
  endtask

  initial begin
    bit [W-1:0] f;
    reset = 1'b1; serIn = 0; serValid = 0; serStart = 0; operandReady = 0;
    @(posedge clk); #1;
    chk("rst_state", int'({opx_l, vld_l, ferr_l, ovr_l, busy_l}), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    cmp_en = 1'b1;

    // 1: beats 1,0,1,1,0,1 LSB first -> 2D, held while not ready
    f = 6'b101101;
    send_frame(f, 1'b0);
    chk("t1_valid_latency", int'(vld_l), 1);
    chk("t1_opx", int'(opx_l), 'h2D);
    idle(10, 1'b0);
    chk("t1_opx_held", int'(opx_l), 'h2D);
    chk("t1_valid_held", int'(vld_l), 1);
    idle(1, 1'b1);
    chk("t1_valid_drop", int'(vld_l), 0);

    // 2: back-to-back 3F then 00, second start on the accept cycle
    send_frame(6'h3F, 1'b0);
    chk("t2_opx_a", int'(opx_l), 'h3F);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    chk("t2_busy_no_gap", int'({vld_l, busy_l}), 1);
    for (int k = 1; k < W; k++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_opx_b", int'({vld_l, opx_l}), 'h40);
    idle(1, 1'b1);

    // 3: mid-frame restart into 15
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    f = 6'h15;
    drive(1'b1, 1'b1, f[0], 1'b0);
    chk("t3_ferr_pulse", int'(ferr_l), 1);
    drive(1'b1, 1'b0, f[1], 1'b0);
    chk("t3_ferr_once", int'(ferr_l), 0);
    for (int k = 2; k < W; k++) drive(1'b1, 1'b0, f[k], 1'b0);
    chk("t3_opx", int'(opx_l), 'h15);
    idle(1, 1'b1);

    // 4: overrun while holding 2A, then accept with a stray beat
    send_frame(6'h2A, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("t4_ovr1", int'(ovr_l), 1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_ovr2", int'(ovr_l), 1);
    idle(1, 1'b0);
    chk("t4_ovr_clear", int'({ovr_l, opx_l}), 'h2A);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    chk("t4_accept_ovr", int'({ovr_l, vld_l, busy_l}), 'b100);

    // 5: reset after 4 bits, then a clean 0C
    for (int k = 0; k < 4; k++) drive(1'b1, k == 0, 1'b1, 1'b0);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_rst_outputs", int'({opx_l, vld_l, ferr_l, ovr_l, busy_l}), 0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5_post_rst_pulses", int'({ferr_l, ovr_l}), 0);
    send_frame(6'h0C, 1'b0);
    chk("t5_opx", int'(opx_l), 'h0C);
    idle(1, 1'b1);

    // 6: MSB-first instance on the same streams
    f = 6'b101101;
    send_frame(f, 1'b0);
    chk("t6_msb_a", int'(opx_m), 'h2D);
    idle(1, 1'b1);
    f = 6'b000011;
    send_frame(f, 1'b0);
    chk("t6_msb_b", int'(opx_m), 'h30);
    chk("t6_lsb_b", int'(opx_l), 'h03);
    idle(2, 1'b1);

    // Non-start beats in IDLE are ignored
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    chk("idle_ignore", int'({busy_l, ferr_l, ovr_l}), 0);
    idle(2, 1'b0);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
